// File: rtl/bht_pkg.sv
// Shared constants, FSM encoding and counter helpers for the BHT controller.
// Optional BHT_STAT_EN build adds lookup/update/stall statistics counters.
package bht_pkg;

    localparam int WIDTH   = 2;
    localparam int ENTRY   = 1024;
    localparam int ADDRESS = 10;
    localparam int QDEPTH  = 4;

    localparam logic [WIDTH-1:0] INIT_VAL = 2'b01;
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN  = '0;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPD_RD,
        UPD_WR
    } bht_state_e;

    typedef struct packed {
        logic [ADDRESS-1:0] idx;
        logic               taken;
    } upd_t;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] c);
        return (c == CNT_MIN) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/bht_if.sv
// Fetch lookup / execute update handshake bundle between the core and the BHT.
// master = core side, slave = bht_ctrl.
interface bht_if;

    logic [31:0] Iadd;
    logic        lk_valid;
    logic        lk_ready;
    logic        pred_valid;
    logic        predict;

    logic [31:0] Badd;
    logic        upd_valid;
    logic        upd_taken;
    logic        upd_ready;

    modport master (
        output Iadd,
        output lk_valid,
        input  lk_ready,
        input  pred_valid,
        input  predict,
        output Badd,
        output upd_valid,
        output upd_taken,
        input  upd_ready
    );

    modport slave (
        input  Iadd,
        input  lk_valid,
        output lk_ready,
        output pred_valid,
        output predict,
        input  Badd,
        input  upd_valid,
        input  upd_taken,
        output upd_ready
    );

endinterface

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates until the RAM is free.
// Head entry is visible combinationally; push and pop may share a cycle.
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int DEPTH = QDEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  upd_t din,
    input  logic pop,
    output upd_t dout,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    upd_t        mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Extra pointer bit distinguishes full from empty when indices match.
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/bht_ctrl.sv
// BHT controller: init walk, fetch lookups and buffered read-modify-write updates
// sharing one single-port RAM. BHT_STAT_EN adds lk_cnt/upd_cnt/stall_cnt outputs.
module bht_ctrl
    import bht_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    bht_if.slave               bus,
    output logic               busy,
    output logic [ADDRESS-1:0] ram_addr,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_wdata,
    input  logic [WIDTH-1:0]   ram_rdata
`ifdef BHT_STAT_EN
    ,
    output logic [31:0]        lk_cnt,
    output logic [31:0]        upd_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    bht_state_e state_q;
    bht_state_e state_d;

    logic [ADDRESS-1:0] ptr_q;
    logic [WIDTH-1:0]   cnt_q;
    logic               pred_q;

    logic lk_rdy;
    logic upd_rdy;
    logic lk_fire;
    logic upd_fire;

    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    upd_t fifo_head;
    upd_t fifo_din;

    // Upper address bits alias onto the same counter by design.
    logic unused_hi;
    assign unused_hi = ^{bus.Iadd[31:ADDRESS], bus.Badd[31:ADDRESS]};

    assign fifo_din = '{idx: bus.Badd[ADDRESS-1:0], taken: bus.upd_taken};

    bht_upd_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (upd_fire),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        lk_rdy    = 1'b0;
        fifo_pop  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                INIT: begin
                    ram_we    = 1'b1;
                    ram_addr  = ptr_q;
                    ram_wdata = INIT_VAL;
                    if (ptr_q == ADDRESS'(ENTRY - 1)) state_d = IDLE;
                end
                IDLE: begin
                    // A full queue preempts lookups so updates cannot starve.
                    if (fifo_full) begin
                        ram_addr = fifo_head.idx;
                        state_d  = UPD_RD;
                    end else begin
                        lk_rdy = 1'b1;
                        if (bus.lk_valid) begin
                            ram_addr = bus.Iadd[ADDRESS-1:0];
                        end else if (!fifo_empty) begin
                            ram_addr = fifo_head.idx;
                            state_d  = UPD_RD;
                        end
                    end
                end
                UPD_RD: begin
                    ram_addr = fifo_head.idx;
                    state_d  = UPD_WR;
                end
                UPD_WR: begin
                    ram_we    = 1'b1;
                    ram_addr  = fifo_head.idx;
                    ram_wdata = fifo_head.taken ? sat_inc(cnt_q)
                                                : sat_dec(cnt_q);
                    fifo_pop  = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = INIT;
            endcase
        end
    end

    assign upd_rdy  = !rst && !fifo_full && (state_q != INIT);
    assign lk_fire  = bus.lk_valid && lk_rdy;
    assign upd_fire = bus.upd_valid && upd_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pred_q  <= lk_fire;
            if (state_q == INIT)   ptr_q <= ptr_q + 1'b1;
            if (state_q == UPD_RD) cnt_q <= ram_rdata;
        end
    end

    assign busy           = rst || (state_q == INIT);
    assign bus.lk_ready   = lk_rdy;
    assign bus.upd_ready  = upd_rdy;
    assign bus.pred_valid = pred_q && !rst;
    assign bus.predict    = pred_q && !rst && ram_rdata[WIDTH-1];

`ifdef BHT_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_cnt    <= '0;
            upd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (lk_fire)  lk_cnt  <= lk_cnt + 1'b1;
            if (upd_fire) upd_cnt <= upd_cnt + 1'b1;
            if (bus.lk_valid && !lk_rdy && (state_q != INIT))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
